// File: rtl/midi_mmio_pkg.sv
// Shared constants and payload types for the MIDI MMIO bridge.
// Holds register offsets, the default MMIO window base, status bit
// positions and the packed read-back layouts of the FIFO registers.
package midi_mmio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 4;

    localparam logic [OFF_W-1:0] RXDATA_OFF = 4'd0;
    localparam logic [OFF_W-1:0] RXSTAT_OFF = 4'd1;
    localparam logic [OFF_W-1:0] TICK_OFF   = 4'd2;
    localparam logic [OFF_W-1:0] NOTE_OFF   = 4'd3;

    localparam logic [DATA_W-1:0] MMIO_BASE_DEFAULT = 32'h0000_F000;

    localparam int unsigned OVF_BIT = 31;

    // RXDATA read-back: head byte plus a nonempty flag in bit 8
    typedef struct packed {
        logic [22:0] rsvd;
        logic        nonempty;
        logic [7:0]  data_byte;
    } rxdata_t;

    // RXSTAT read-back: sticky overflow in bit 31, entry count in [7:0]
    typedef struct packed {
        logic        ovf;
        logic [22:0] rsvd;
        logic [7:0]  count;
    } rxstat_t;

endpackage

// File: rtl/midi_mmio_bridge_if.sv
// Processor dmem-port bundle seen by the bridge.
//   master: processor side (drives address_dmem/data/wren/rden, takes q_dmem)
//   slave : bridge side
interface midi_mmio_bridge_if;
    import midi_mmio_pkg::*;

    logic [DATA_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic              rden;
    logic [DATA_W-1:0] q_dmem;

    modport master (output address_dmem, data, wren, rden, input q_dmem);
    modport slave  (input address_dmem, data, wren, rden, output q_dmem);

endinterface

// File: rtl/midi_mmio_bridge_sync_fifo.sv
// sync_fifo: single-clock FIFO with simultaneous push/pop support.
// Ports: clk, rst (async active-high), push, pop, wdata,
//        head_c (front entry), full_c, empty_c, count,
//        drop_c (push refused because full with no pop this cycle).
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head_c,
    output logic                         full_c,
    output logic                         empty_c,
    output logic                         drop_c,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_do;
    logic             push_do;

    assign empty_c = (count == '0);
    assign full_c  = (count == CW'(DEPTH));
    assign head_c  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    assign pop_do  = pop && !empty_c;
    assign push_do = push && (!full_c || pop_do);
    assign drop_c  = push && full_c && !pop_do;

    // Storage array: no reset needed, validity tracked by count
    always_ff @(posedge clk) begin
        if (push_do) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_do) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_do) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_do && !pop_do) begin
                count <= count + CW'(1);
            end else if (pop_do && !push_do) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/midi_mmio_bridge.sv
// midi_mmio_bridge: decodes processor dmem accesses into RAM traffic or a
// 16-word MMIO register window (MIDI RX FIFO, status, tick counter, note).
// Ports: clock, reset (async active-high); dmem (slave modport: address_dmem,
//        data, wren, rden, q_dmem); ram_addr/ram_data/ram_wren/ram_q to RAM;
//        midi_byte/midi_valid from the UART; note_out to the synth voice;
//        rx_nonempty FIFO status.
// Build option: define MIDI_MMIO_TICK_EN to include the free-running TICK
// counter; otherwise offset 2 reads 0 and ignores writes.
module midi_mmio_bridge
    import midi_mmio_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int unsigned       RAM_AW     = 12
) (
    input  logic                clock,
    input  logic                reset,
    midi_mmio_bridge_if.slave   dmem,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_wren,
    input  logic [DATA_W-1:0]   ram_q,
    input  logic [7:0]          midi_byte,
    input  logic                midi_valid,
    output logic [DATA_W-1:0]   note_out,
    output logic                rx_nonempty
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic             hit;
    logic [OFF_W-1:0] off;
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [CW-1:0]    fifo_count;
    logic             overflow;
    logic [DATA_W-1:0] tick_rd;
    logic [DATA_W-1:0] q_c;
    rxdata_t          rxdata_c;
    rxstat_t          rxstat_c;

    assign hit = (dmem.address_dmem[DATA_W-1:OFF_W] == MMIO_BASE[DATA_W-1:OFF_W]);
    assign off = dmem.address_dmem[OFF_W-1:0];

    assign ram_addr = dmem.address_dmem[RAM_AW-1:0];
    assign ram_data = dmem.data;
    assign ram_wren = dmem.wren && !hit;

    // Pop only on a real load of RXDATA with data present
    assign fifo_pop = dmem.rden && hit && (off == RXDATA_OFF) && !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clock),
        .rst     (reset),
        .push    (midi_valid),
        .pop     (fifo_pop),
        .wdata   (midi_byte),
        .head_c  (fifo_head),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .drop_c  (fifo_drop),
        .count   (fifo_count)
    );

    assign rx_nonempty = !fifo_empty;

    // Sticky overflow; a drop in the same cycle as a clearing write wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end else if (dmem.wren && hit && (off == RXSTAT_OFF)) begin
            overflow <= 1'b0;
        end
    end

    // Note-control register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            note_out <= '0;
        end else if (dmem.wren && hit && (off == NOTE_OFF)) begin
            note_out <= dmem.data;
        end
    end

`ifdef MIDI_MMIO_TICK_EN
    logic [DATA_W-1:0] tick;

    // Free-running counter; a write loads data+1 so the following cycle
    // already reflects one elapsed tick past the written value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick <= '0;
        end else if (dmem.wren && hit && (off == TICK_OFF)) begin
            tick <= dmem.data + DATA_W'(1);
        end else begin
            tick <= tick + DATA_W'(1);
        end
    end

    assign tick_rd = tick;
`else
    assign tick_rd = '0;
`endif

    // Register read-back layouts
    always_comb begin
        rxdata_c           = '0;
        rxdata_c.nonempty  = !fifo_empty;
        rxdata_c.data_byte = fifo_empty ? 8'h00 : fifo_head;
        if (fifo_empty) begin
            rxdata_c = '0;
        end
        rxstat_c       = '0;
        rxstat_c.ovf   = overflow;
        rxstat_c.count = 8'(fifo_count);
    end

    // Load data mux: register map inside the window, RAM otherwise
    always_comb begin
        q_c = ram_q;
        if (hit) begin
            case (off)
                RXDATA_OFF: q_c = rxdata_c;
                RXSTAT_OFF: q_c = rxstat_c;
                TICK_OFF:   q_c = tick_rd;
                NOTE_OFF:   q_c = note_out;
                default:    q_c = '0;
            endcase
        end
    end

    assign dmem.q_dmem = q_c;

endmodule

// File: tb/tb_midi_mmio_bridge.sv
// Self-checking bench for midi_mmio_bridge: directed scenarios followed by
// randomized traffic checked against a queue-based reference model.
module tb_midi_mmio_bridge;

    localparam int unsigned DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0000_F000;
    localparam int unsigned RAM_AW = 12;

    logic              clock;
    logic              reset;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic [31:0]       ram_q;
    logic [7:0]        midi_byte;
    logic              midi_valid;
    logic [31:0]       note_out;
    logic              rx_nonempty;

    midi_mmio_bridge_if dmem_bus ();

    midi_mmio_bridge #(
        .FIFO_DEPTH (DEPTH),
        .MMIO_BASE  (BASE),
        .RAM_AW     (RAM_AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .dmem        (dmem_bus),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .midi_byte   (midi_byte),
        .midi_valid  (midi_valid),
        .note_out    (note_out),
        .rx_nonempty (rx_nonempty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    bit [7:0]  m_fifo[$];
    bit        m_ovf;
    bit [31:0] m_note;
    bit [31:0] m_tick;
    logic      last_wren;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] rq);
        if (!in_window(a)) return rq;
        case (a[3:0])
            4'd0: return (m_fifo.size() == 0) ? 32'h0 : (32'h100 | 32'(m_fifo[0]));
            4'd1: return {m_ovf, 23'b0, 8'(m_fifo.size())};
`ifdef MIDI_MMIO_TICK_EN
            4'd2: return m_tick;
`else
            4'd2: return 32'h0;
`endif
            4'd3: return m_note;
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge worth of architectural effects
    task automatic model_step(input logic [31:0] a, input logic [31:0] wd,
                              input bit we, input bit re, input bit [7:0] mb, input bit mv);
        bit h;
        h = in_window(a);
        if (h && re && a[3:0] == 4'd0 && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (h && we && a[3:0] == 4'd1) m_ovf = 1'b0;
        if (mv) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(mb);
            else m_ovf = 1'b1;
        end
        if (h && we && a[3:0] == 4'd3) m_note = wd;
        if (h && we && a[3:0] == 4'd2) m_tick = wd + 32'd1;
        else m_tick = m_tick + 32'd1;
    endtask

    task automatic drive_idle();
        dmem_bus.address_dmem = 32'h0;
        dmem_bus.data         = 32'h0;
        dmem_bus.wren         = 1'b0;
        dmem_bus.rden         = 1'b0;
        midi_byte             = 8'h00;
        midi_valid            = 1'b0;
        ram_q                 = 32'h0;
    endtask

    // Called just after a posedge; returns the load data seen in that cycle
    task automatic do_cycle(input logic [31:0] a, input logic [31:0] wd,
                            input bit we, input bit re, input bit [7:0] mb, input bit mv,
                            output logic [31:0] q_seen);
        dmem_bus.address_dmem = a;
        dmem_bus.data         = wd;
        dmem_bus.wren         = we;
        dmem_bus.rden         = re;
        midi_byte             = mb;
        midi_valid            = mv;
        ram_q                 = $urandom;
        @(negedge clock);
        q_seen    = dmem_bus.q_dmem;
        last_wren = ram_wren;
        check("q_dmem", q_seen, model_read(a, ram_q));
        check("ram_addr", 32'(ram_addr), 32'(a[RAM_AW-1:0]));
        check("ram_data", ram_data, wd);
        check("ram_wren", 32'(ram_wren), 32'(we && !in_window(a)));
        check("note_out", note_out, m_note);
        check("rx_nonempty", 32'(rx_nonempty), 32'(m_fifo.size() != 0));
        @(posedge clock);
        model_step(a, wd, we, re, mb, mv);
        #1;
    endtask

    // Asynchronous reset; any push/pop driven at this moment is lost
    task automatic apply_reset();
        reset = 1'b1;
        drive_idle();
        m_fifo.delete();
        m_ovf  = 1'b0;
        m_note = 32'h0;
        m_tick = 32'h0;
        #1;
        for (int i = 0; i < 4; i++) begin
            dmem_bus.address_dmem = BASE + 32'(i);
            #1;
            check($sformatf("rst_q_off%0d", i), dmem_bus.q_dmem, 32'h0);
        end
        check("rst_note_out", note_out, 32'h0);
        check("rst_rx_nonempty", 32'(rx_nonempty), 32'h0);
        dmem_bus.address_dmem = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        model_step(32'h0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
    endtask

    logic [31:0] qs;
    bit [7:0]    bytes17 [17];
    bit [7:0]    xb;
    logic [31:0] a;
    logic [31:0] saved_note;

    initial begin
        reset = 1'b1;
        drive_idle();
        #12;
        apply_reset();

        // Three pushes, three pops in order, then empty
        do_cycle(32'h0, 32'h0, 0, 0, 8'h90, 1, qs);
        do_cycle(32'h0, 32'h0, 0, 0, 8'h3C, 1, qs);
        do_cycle(32'h0, 32'h0, 0, 0, 8'h7F, 1, qs);
        do_cycle(BASE, 32'h0, 0, 1, 8'h00, 0, qs); check("pop_90", qs, 32'h190);
        do_cycle(BASE, 32'h0, 0, 1, 8'h00, 0, qs); check("pop_3c", qs, 32'h13C);
        do_cycle(BASE, 32'h0, 0, 1, 8'h00, 0, qs); check("pop_7f", qs, 32'h17F);
        do_cycle(BASE, 32'h0, 0, 1, 8'h00, 0, qs); check("pop_empty", qs, 32'h0);
        do_cycle(BASE + 1, 32'h0, 0, 0, 8'h00, 0, qs); check("stat_empty", qs, 32'h0);

        // Overfill by one, clear overflow, then push+pop while full
        for (int i = 0; i < 17; i++) begin
            bytes17[i] = 8'($urandom);
            do_cycle(32'h0, 32'h0, 0, 0, bytes17[i], 1, qs);
        end
        do_cycle(BASE + 1, 32'h0, 0, 0, 8'h00, 0, qs); check("stat_ovf", qs, 32'h8000_0010);
        do_cycle(BASE + 1, 32'h1234, 1, 0, 8'h00, 0, qs);
        do_cycle(BASE + 1, 32'h0, 0, 0, 8'h00, 0, qs); check("stat_clr", qs, 32'h0000_0010);
        xb = 8'($urandom);
        do_cycle(BASE, 32'h0, 0, 1, xb, 1, qs); check("full_pushpop", qs, 32'h100 | 32'(bytes17[0]));
        do_cycle(BASE + 1, 32'h0, 0, 0, 8'h00, 0, qs); check("stat_full_pp", qs, 32'h0000_0010);
        for (int i = 1; i < 16; i++) begin
            do_cycle(BASE, 32'h0, 0, 1, 8'h00, 0, qs);
            check($sformatf("drain_%0d", i), qs, 32'h100 | 32'(bytes17[i]));
        end
        do_cycle(BASE, 32'h0, 0, 1, 8'h00, 0, qs); check("drain_last", qs, 32'h100 | 32'(xb));
        do_cycle(BASE, 32'h0, 0, 1, 8'h00, 0, qs); check("drain_empty", qs, 32'h0);

        // Push and pop on an empty FIFO: push only, read returns 0
        do_cycle(BASE, 32'h0, 0, 1, 8'hA5, 1, qs); check("empty_pushpop", qs, 32'h0);
        do_cycle(BASE, 32'h0, 0, 1, 8'h00, 0, qs); check("empty_pp_pop", qs, 32'h1A5);

        // TICK wrap
        do_cycle(BASE + 2, 32'hFFFF_FFFE, 1, 0, 8'h00, 0, qs);
        do_cycle(BASE + 2, 32'h0, 0, 1, 8'h00, 0, qs);
`ifdef MIDI_MMIO_TICK_EN
        check("tick_ffff", qs, 32'hFFFF_FFFF);
`else
        check("tick_off_0", qs, 32'h0);
`endif
        do_cycle(BASE + 2, 32'h0, 0, 1, 8'h00, 0, qs); check("tick_wrap", qs, 32'h0);

        // RAM store/load and NOTE store
        saved_note = note_out;
        do_cycle(32'h5, 32'hDEAD_BEEF, 1, 0, 8'h00, 0, qs);
        check("ram_st_wren", 32'(last_wren), 32'h1);
        check("ram_st_note", note_out, saved_note);
        do_cycle(32'h5, 32'h0, 0, 1, 8'h00, 0, qs); check("ram_ld", qs, ram_q);
        do_cycle(BASE + 3, 32'h0000_403C, 1, 0, 8'h00, 0, qs);
        check("note_st_wren", 32'(last_wren), 32'h0);
        check("note_out_403c", note_out, 32'h0000_403C);

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 6)       a = BASE + 32'($urandom_range(0, 5));
            else if (r == 6) a = BASE + 32'($urandom_range(6, 15));
            else if (r == 7) a = $urandom;
            else             a = 32'($urandom_range(0, 4095));
            if (i % 250 == 249) begin
                dmem_bus.address_dmem = BASE;
                dmem_bus.rden         = 1'b1;
                midi_byte             = 8'($urandom);
                midi_valid            = 1'b1;
                #2;
                apply_reset();
            end else begin
                do_cycle(a, $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                         8'($urandom), ($urandom_range(0, 1) == 1), qs);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
